// File: rtl/fb_pkg.sv
// Shared framebuffer types: FSM states, default burst length, pixel word.
// Common to the reader and the pattern/pixel writers.
package fb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } fb_state_t;

  localparam int unsigned FB_BURST = 64;

  typedef logic [31:0] pixel_t;

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 pipelined bus bundle with clock and reset carried alongside.
interface wshb_if (
  input logic clk,
  input logic rst
);

  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic        ack;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;

  modport master (
    input  clk, rst, dat_sm, ack,
    output adr, dat_ms, cyc, stb, we, sel, cti, bte
  );

  modport slave (
    input  clk, rst, adr, dat_ms, cyc, stb, we, sel, cti, bte,
    output dat_sm, ack
  );

endinterface

// File: rtl/fb_addr_gen.sv
// Raster pixel counter with matching byte address; wraps to BASE_ADR after
// the last pixel of the frame. Shared by the framebuffer reader and writers.
module fb_addr_gen
  import fb_pkg::*;
#(
  parameter int unsigned HDISP    = 800,
  parameter int unsigned VDISP    = 480,
  parameter logic [31:0] BASE_ADR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        clear,
  output logic [31:0] adr,
  output logic        last_pixel
);

  localparam int unsigned NPIX = HDISP * VDISP;
  localparam int unsigned PW   = $clog2(NPIX);

  logic [PW-1:0] pcnt;

  assign last_pixel = (pcnt == PW'(NPIX - 1));

  // clear wins over inc so a restart coinciding with an ack still lands on pixel 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
      adr  <= BASE_ADR;
    end else if (clear || (inc && last_pixel)) begin
      pcnt <= '0;
      adr  <= BASE_ADR;
    end else if (inc) begin
      pcnt <= pcnt + 1'b1;
      adr  <= adr + 32'd4;
    end
  end

endmodule

// File: rtl/fb_reader.sv
// Wishbone burst-read master streaming the framebuffer in raster order into
// the display pixel FIFO, paced by the FIFO almost-full flag.
module fb_reader
  import fb_pkg::*;
#(
  parameter int unsigned HDISP    = 800,
  parameter int unsigned VDISP    = 480,
  parameter int unsigned BURST    = FB_BURST,
  parameter logic [31:0] BASE_ADR = 32'h0
) (
  wshb_if.master wshb_ifm,
  input  logic   fifo_afull,
  input  logic   frame_start,
  output pixel_t fifo_wdata,
  output logic   fifo_write
);

  localparam int unsigned BW = $clog2(BURST) + 1;

  logic          clk;
  logic          rst;
  fb_state_t     state;
  fb_state_t     next_state;
  logic [BW-1:0] bcnt;
  logic          restart_pend;
  logic          stb_int;
  logic          accept;
  logic          burst_done;
  logic          last_pixel;
  logic          ag_clear;
  logic [31:0]   adr_int;

  assign clk = wshb_ifm.clk;
  assign rst = wshb_ifm.rst;

  assign accept     = stb_int && wshb_ifm.ack;
  assign burst_done = accept && ((bcnt == BW'(BURST - 1)) || last_pixel);

  // A restart is honoured either immediately in IDLE or at the end of the burst
  assign ag_clear = ((state == IDLE) && frame_start) ||
                    (burst_done && (restart_pend || frame_start));

  fb_addr_gen #(
    .HDISP   (HDISP),
    .VDISP   (VDISP),
    .BASE_ADR(BASE_ADR)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .inc       (accept),
    .clear     (ag_clear),
    .adr       (adr_int),
    .last_pixel(last_pixel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!fifo_afull && !frame_start && !restart_pend) next_state = READ;
      READ:    if (burst_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    stb_int = (state == READ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt         <= '0;
      restart_pend <= 1'b0;
    end else begin
      if (state == IDLE) bcnt <= '0;
      else if (accept)   bcnt <= bcnt + 1'b1;

      if (burst_done)                          restart_pend <= 1'b0;
      else if ((state == READ) && frame_start) restart_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_write <= 1'b0;
      fifo_wdata <= '0;
    end else begin
      fifo_write <= accept;
      if (accept) fifo_wdata <= wshb_ifm.dat_sm;
    end
  end

  assign wshb_ifm.adr    = adr_int;
  assign wshb_ifm.dat_ms = '0;
  assign wshb_ifm.stb    = stb_int;
  assign wshb_ifm.cyc    = stb_int;
  assign wshb_ifm.we     = 1'b0;
  assign wshb_ifm.sel    = 4'b1111;
  assign wshb_ifm.cti    = 3'b000;
  assign wshb_ifm.bte    = 2'b00;

endmodule

// File: tb/tb_fb_reader.sv
// Directed bench for fb_reader on a 10x10 frame with 64-word bursts; the
// slave model returns dat_sm = adr so every FIFO word encodes its address.
module tb_fb_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_afull = 1'b0;
  logic        frame_start = 1'b0;
  logic [31:0] fifo_wdata;
  logic        fifo_write;
  logic        allow = 1'b1;
  logic        spur = 1'b0;

  int unsigned cyc_n = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  logic [31:0] wq[$];
  int unsigned wc[$];
  logic [31:0] sq[$];
  int unsigned sc[$];
  int unsigned n_acc = 0;
  logic        stb_d = 1'b0;

  wshb_if wshb (.clk(clk), .rst(rst));

  assign wshb.ack    = (wshb.stb & allow) | spur;
  assign wshb.dat_sm = wshb.adr;

  fb_reader #(
    .HDISP   (10),
    .VDISP   (10),
    .BURST   (64),
    .BASE_ADR(32'h0)
  ) dut (
    .wshb_ifm   (wshb),
    .fifo_afull (fifo_afull),
    .frame_start(frame_start),
    .fifo_wdata (fifo_wdata),
    .fifo_write (fifo_write)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (fifo_write) begin
      wq.push_back(fifo_wdata);
      wc.push_back(cyc_n);
    end
    if (wshb.stb && !stb_d) begin
      sq.push_back(wshb.adr);
      sc.push_back(cyc_n);
    end
    if (wshb.stb && wshb.ack) n_acc <= n_acc + 1;
    stb_d <= wshb.stb;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    wq.delete();
    wc.delete();
    sq.delete();
    sc.delete();
    n_acc = 0;
  endtask

  task automatic do_reset(output int unsigned c0);
    rst = 1'b1;
    tick(3);
    clear_mon();
    rst = 1'b0;
    c0 = cyc_n;
  endtask

  function automatic int unsigned seq_errors();
    int unsigned bad = 0;
    foreach (wq[i]) if (wq[i] !== 32'((i * 4) % 400)) bad++;
    return bad;
  endfunction

  initial begin
    int unsigned c0;
    int unsigned ca;
    int unsigned gap;

    // reset values
    tick(2);
    @(negedge clk);
    check("rst_stb",   32'(wshb.stb), 32'd0);
    check("rst_cyc",   32'(wshb.cyc), 32'd0);
    check("rst_adr",   wshb.adr, 32'h0);
    check("rst_fwr",   32'(fifo_write), 32'd0);
    check("rst_fdata", fifo_wdata, 32'h0);
    check("rst_we",    32'(wshb.we), 32'd0);
    check("rst_sel",   32'(wshb.sel), 32'hf);
    check("rst_cti",   32'(wshb.cti), 32'd0);
    check("rst_bte",   32'(wshb.bte), 32'd0);

    // first bursts from reset, frame wrap after pixel 99
    fifo_afull = 1'b0;
    do_reset(c0);
    tick(140);
    check("t1_nbursts", 32'(sq.size() >= 3), 32'd1);
    if (sq.size() >= 3) begin
      check("t1_stb_lat",   sc[0] - c0, 32'd1);
      check("t1_adr0",      sq[0], 32'd0);
      check("t1_adr1",      sq[1], 32'd256);
      check("t1_gap1",      sc[1] - sc[0], 32'd65);
      check("t1_wrap_adr",  sq[2], 32'd0);
      check("t1_trunc_len", sc[2] - sc[1], 32'd37);
    end
    check("t1_nwrites", 32'(wq.size() >= 101), 32'd1);
    if (wq.size() >= 101 && sc.size() >= 1) begin
      check("t1_fifo_lat", wc[0] - sc[0], 32'd1);
      check("t1_w63",  wq[63], 32'd252);
      check("t1_w64",  wq[64], 32'd256);
      check("t1_w99",  wq[99], 32'd396);
      check("t1_w100", wq[100], 32'd0);
    end
    check("t1_seq", seq_errors(), 32'd0);

    // almost-full hold, then afull raised mid-burst
    fifo_afull = 1'b1;
    do_reset(c0);
    tick(100);
    check("t2_hold_stb",  32'(sq.size()), 32'd0);
    check("t2_hold_wr",   32'(wq.size()), 32'd0);
    fifo_afull = 1'b0;
    ca = cyc_n;
    tick(10);
    fifo_afull = 1'b1;
    tick(80);
    check("t2_nbursts", 32'(sq.size()), 32'd1);
    if (sq.size() >= 1) begin
      check("t2_start_lat", sc[0] - ca, 32'd1);
      check("t2_adr0",      sq[0], 32'd0);
    end
    check("t2_nwrites", 32'(wq.size()), 32'd64);
    if (wq.size() >= 64) check("t2_w63", wq[63], 32'd252);

    // frame_start during word 20 of a burst
    fifo_afull = 1'b0;
    do_reset(c0);
    tick(21);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    tick(80);
    check("t4_nbursts", 32'(sq.size() >= 2), 32'd1);
    if (sq.size() >= 2) begin
      check("t4_restart_adr", sq[1], 32'd0);
      check("t4_burst_len",   sc[1] - sc[0], 32'd65);
    end
    if (wq.size() >= 65) begin
      check("t4_w20", wq[20], 32'd80);
      check("t4_w63", wq[63], 32'd252);
      check("t4_w64", wq[64], 32'd0);
    end else check("t4_nwrites", 32'(wq.size()), 32'd65);

    // frame_start while idle
    do_reset(c0);
    tick(10);
    fifo_afull = 1'b1;
    tick(70);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    tick(3);
    fifo_afull = 1'b0;
    tick(5);
    check("t4b_nbursts", 32'(sq.size()), 32'd2);
    if (sq.size() >= 2) check("t4b_restart_adr", sq[1], 32'd0);
    if (wq.size() >= 65) check("t4b_w64", wq[64], 32'd0);
    else check("t4b_nwrites", 32'(wq.size() >= 65), 32'd1);

    // random ack gaps with spurious acks while stb is low
    fifo_afull = 1'b0;
    do_reset(c0);
    gap = 0;
    for (int i = 0; i < 400; i++) begin
      spur = !wshb.stb;
      if (gap > 0) begin
        allow = 1'b0;
        gap--;
      end else begin
        allow = 1'b1;
        gap = $urandom_range(0, 5);
      end
      tick(1);
    end
    spur = 1'b0;
    allow = 1'b1;
    fifo_afull = 1'b1;
    tick(80);
    check("t5_enough_acks", 32'(n_acc > 100), 32'd1);
    check("t5_count",       32'(wq.size()), 32'(n_acc));
    check("t5_seq",         seq_errors(), 32'd0);

    // asynchronous reset during word 30
    fifo_afull = 1'b0;
    do_reset(c0);
    tick(30);
    @(posedge clk);
    #7;
    rst = 1'b1;
    #1;
    check("t6_stb_async", 32'(wshb.stb), 32'd0);
    check("t6_cyc_async", 32'(wshb.cyc), 32'd0);
    check("t6_fwr_async", 32'(fifo_write), 32'd0);
    tick(3);
    check("t6_nwrites", 32'(wq.size()), 32'd30);
    if (wq.size() >= 30) check("t6_w29", wq[29], 32'd116);
    rst = 1'b0;
    tick(5);
    check("t6_nbursts", 32'(sq.size()), 32'd2);
    if (sq.size() >= 2) check("t6_restart_adr", sq[1], 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_reader.md
# fb_reader

Wishbone burst-read master that streams the framebuffer out of SDRAM in raster order and pushes each 32-bit pixel word into the display pixel FIFO. It is the read-side counterpart of the pattern and pixel writers. It shares the SDRAM controller through the Wishbone arbiter and paces itself on the FIFO almost-full flag. The frame restarts from address 0 on each frame-start pulse from the video timing block.

## Interface
- HDISP, 800, active pixels per line
- VDISP, 480, active lines per frame
- BURST, 64, words per Wishbone burst; power of two, ≤ HDISP*VDISP
- BASE_ADR, 32'h0, byte address of pixel (0,0)

Ports:
- wshb_ifm.clk  in  1  system clock; all logic on rising edge
- wshb_ifm.rst  in  1  reset, asynchronous, active-high
- wshb_ifm  (wshb_if.master)  —  Wishbone master port: adr[31:0], dat_sm[31:0] in, ack in, cyc/stb/we/sel[3:0]/cti[2:0]/bte[1:0] out
- fifo_afull  in  1  pixel FIFO almost full; low guarantees ≥ BURST+2 free entries
- frame_start  in  1  single-cycle pulse: restart reading at pixel 0
- fifo_wdata  out  32  pixel word to FIFO
- fifo_write  out  1  FIFO write strobe

## Operation
- Constant outputs: we=0, sel=4'b1111, cti=3'b000, bte=2'b00, cyc=stb.
- FSM states: IDLE, READ.
- IDLE → READ when fifo_afull=0 and no restart is pending. On entry: stb←1, burst counter←0.
- READ: stb held high. Each cycle with ack=1:
  - capture dat_sm,
  - adr += 4,
  - pixel counter += 1,
  - burst counter += 1.
- READ → IDLE (stb←0) on the ack that completes BURST words, or on the ack of the last pixel of the frame (pixel HDISP*VDISP−1), whichever comes first. fifo_afull is not sampled during READ.
- Frame wrap: the ack of the last pixel sets adr←BASE_ADR and pixel counter←0. The next burst starts at pixel 0.
- frame_start:
  - In IDLE: adr←BASE_ADR, pixel counter←0 next cycle. The FSM stays in IDLE that cycle.
  - In READ: latched as restart_pend. The burst completes normally. On the READ → IDLE transition, adr/counter are cleared and restart_pend is cleared.
  - A second pulse while a restart is already pending is absorbed.
- Pixel counter width: $clog2(HDISP*VDISP). Burst counter width: $clog2(BURST)+1. Address arithmetic is 32-bit unsigned with no overflow handling.
- ack while stb=0 is ignored: no capture, no count.

## Timing
- Reset values: stb=0, cyc=0, adr=BASE_ADR, fifo_wdata=0, fifo_write=0, state=IDLE, counters=0, restart_pend=0.
- Reset mid-burst drops stb/cyc asynchronously. No FIFO write is issued for a pending ack.
- FIFO path latency is 1 cycle: ack at cycle n gives fifo_write=1 and fifo_wdata=dat_sm(n) at cycle n+1. fifo_write is high for exactly one cycle per accepted ack.
- Minimum one IDLE cycle (stb=0) between consecutive bursts. Back-to-back bursts therefore have a 1-cycle gap.
- First stb rises one cycle after fifo_afull is sampled low in IDLE.
- Throughput is bounded by the arbiter. The block tolerates ack gaps of any length.

## Structure
- Package fb_pkg: state enum (IDLE, READ), default BURST, pixel-word type (logic [31:0]), shared with the writer blocks.
- Sub-module fb_addr_gen: pixel counter plus byte address.
  - Inputs: inc, clear.
  - Outputs: adr, last_pixel.
  - Also reused by the writers.
- FSM, burst counter, restart latch and FIFO output register stay in fb_reader.

## Test plan
- Reset release with fifo_afull=0 and an always-ack slave returning dat_sm=adr → stb rises at cycle 1. Adr steps 0,4,…,252. 64 fifo_writes carry data 0..252. Then 1 IDLE cycle, next burst at adr 256.
- fifo_afull=1 held for 100 cycles, then 0 → no stb during the hold. Burst starts 1 cycle after release. Assert fifo_afull mid-burst → burst still completes all 64 words.
- Full frame with HDISP=10, VDISP=10, BURST=64 → second burst is truncated to 36 words and ends at adr 396. Next burst starts at adr 0.
- frame_start mid-burst at word 20 → burst completes 64 words. Next burst starts at adr 0. Pulse while idle → next burst at adr 0.
- Random ack gaps (0–5 cycles) → FIFO receives exactly the acked words in order with no duplicates. Spurious ack with stb=0 is ignored.
- Async reset at word 30 → stb/cyc low immediately, no further fifo_write. After release, reading restarts at adr 0.
